// File: rtl/flip_event_counter.sv
// rtl/flip_event_counter.sv - synchronizes a toggle-encoded event line and keeps event count / gap statistics
module flip_event_counter #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 32,
   parameter int GAP_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flip_in,
   input  logic                 enable,
   input  logic                 clear,
   output logic                 event_pulse,
   output logic [CNT_WIDTH-1:0] event_count,
   output logic                 overflow,
   output logic [GAP_WIDTH-1:0] last_gap,
   output logic                 gap_valid,
   output logic [GAP_WIDTH-1:0] max_gap
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   flip_prev_q, flip_prev_d;
   logic                   event_pulse_q, event_pulse_d;
   logic [CNT_WIDTH-1:0]   event_count_q, event_count_d;
   logic                   overflow_q, overflow_d;
   logic [GAP_WIDTH-1:0]   gap_q, gap_d;
   logic [GAP_WIDTH-1:0]   last_gap_q, last_gap_d;
   logic                   gap_valid_q, gap_valid_d;
   logic [GAP_WIDTH-1:0]   max_gap_q, max_gap_d;
   logic                   first_seen_q, first_seen_d;

   logic flip_sync;
   logic event_det;
   logic counted;

   assign flip_sync = sync_q[SYNC_STAGES-1];
   assign event_det = flip_sync ^ flip_prev_q;
   assign counted   = event_det & enable & ~clear;

   always_comb begin
      sync_d        = {sync_q[SYNC_STAGES-2:0], flip_in};
      flip_prev_d   = flip_sync;
      event_pulse_d = event_det;
      event_count_d = event_count_q;
      overflow_d    = overflow_q;
      gap_d         = gap_q;
      last_gap_d    = last_gap_q;
      gap_valid_d   = gap_valid_q;
      max_gap_d     = max_gap_q;
      first_seen_d  = first_seen_q;

      if (clear) begin
         event_count_d = '0;
         overflow_d    = 1'b0;
         gap_d         = '0;
         last_gap_d    = '0;
         gap_valid_d   = 1'b0;
         max_gap_d     = '0;
         first_seen_d  = 1'b0;
      end else begin
         if (enable && gap_q != '1) begin
            gap_d = gap_q + GAP_WIDTH'(1);
         end
         if (counted) begin
            if (event_count_q == '1) begin
               overflow_d = 1'b1;
            end else begin
               event_count_d = event_count_q + CNT_WIDTH'(1);
            end
            // The event cycle itself is the first cycle of the next gap.
            gap_d = GAP_WIDTH'(1);
            if (first_seen_q) begin
               last_gap_d  = gap_q;
               gap_valid_d = 1'b1;
               if (gap_q > max_gap_q) begin
                  max_gap_d = gap_q;
               end
            end else begin
               first_seen_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q        <= '0;
         flip_prev_q   <= 1'b0;
         event_pulse_q <= 1'b0;
         event_count_q <= '0;
         overflow_q    <= 1'b0;
         gap_q         <= '0;
         last_gap_q    <= '0;
         gap_valid_q   <= 1'b0;
         max_gap_q     <= '0;
         first_seen_q  <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         flip_prev_q   <= flip_prev_d;
         event_pulse_q <= event_pulse_d;
         event_count_q <= event_count_d;
         overflow_q    <= overflow_d;
         gap_q         <= gap_d;
         last_gap_q    <= last_gap_d;
         gap_valid_q   <= gap_valid_d;
         max_gap_q     <= max_gap_d;
         first_seen_q  <= first_seen_d;
      end
   end

   assign event_pulse = event_pulse_q;
   assign event_count = event_count_q;
   assign overflow    = overflow_q;
   assign last_gap    = last_gap_q;
   assign gap_valid   = gap_valid_q;
   assign max_gap     = max_gap_q;

endmodule

// File: tb/tb_flip_event_counter.sv
// tb/tb_flip_event_counter.sv - directed bench for flip_event_counter (default and narrow instances)
module tb_flip_event_counter;

   logic clk = 1'b0;
   logic rst, flip_in, enable, clear;

   logic        b_pulse, b_ovf, b_valid;
   logic [31:0] b_count;
   logic [15:0] b_last, b_max;

   logic        s_pulse, s_ovf, s_valid;
   logic [3:0]  s_count;
   logic [3:0]  s_last, s_max;

   int checks = 0;
   int failures = 0;
   int pulses;

   always #5 clk = ~clk;

   flip_event_counter u_dut (
      .clk(clk), .rst(rst), .flip_in(flip_in), .enable(enable), .clear(clear),
      .event_pulse(b_pulse), .event_count(b_count), .overflow(b_ovf),
      .last_gap(b_last), .gap_valid(b_valid), .max_gap(b_max)
   );

   flip_event_counter #(.SYNC_STAGES(2), .CNT_WIDTH(4), .GAP_WIDTH(4)) u_small (
      .clk(clk), .rst(rst), .flip_in(flip_in), .enable(enable), .clear(clear),
      .event_pulse(s_pulse), .event_count(s_count), .overflow(s_ovf),
      .last_gap(s_last), .gap_valid(s_valid), .max_gap(s_max)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_count(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (b_pulse) cnt++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flip_in = 1'b0; enable = 1'b1; clear = 1'b0;
      step(2);
      check("rst_pulse", b_pulse, 0);
      check("rst_count", b_count, 0);
      check("rst_max",   b_max, 0);
      rst = 1'b0;
      step(3);

      // single 0->1 change: pulse after the 3rd edge only
      flip_in = 1'b1;
      step(2);
      check("t1_pulse_e2", b_pulse, 0);
      step(1);
      check("t1_pulse_e3", b_pulse, 1);
      check("t1_count",    b_count, 1);
      check("t1_valid",    b_valid, 0);
      step(1);
      check("t1_pulse_e4", b_pulse, 0);

      // gaps of 10 then 25
      do_clear();
      check("t2_clr_count", b_count, 0);
      flip_in = ~flip_in; step(10);
      flip_in = ~flip_in; step(25);
      check("t2_last10",   b_last, 10);
      check("t2_s_last10", s_last, 10);
      flip_in = ~flip_in; step(5);
      check("t2_last25",   b_last, 25);
      check("t2_max25",    b_max, 25);
      check("t2_count3",   b_count, 3);
      check("t2_valid",    b_valid, 1);
      check("t2_s_sat15",  s_last, 15);
      check("t2_s_max15",  s_max, 15);

      // 17 back-to-back events
      do_clear();
      for (int i = 0; i < 17; i++) begin
         flip_in = ~flip_in; step(1);
      end
      step(4);
      check("t3_b_count17", b_count, 17);
      check("t3_b_last1",   b_last, 1);
      check("t3_b_max1",    b_max, 1);
      check("t3_b_ovf",     b_ovf, 0);
      check("t3_s_count15", s_count, 15);
      check("t3_s_ovf",     s_ovf, 1);
      do_clear();
      check("t3_s_clr_count", s_count, 0);
      check("t3_s_clr_ovf",   s_ovf, 0);
      check("t3_s_clr_last",  s_last, 0);
      check("t3_s_clr_valid", s_valid, 0);
      check("t3_s_clr_max",   s_max, 0);

      // enable low: pulses still flow, statistics frozen
      enable = 1'b0;
      begin
         int total = 0;
         for (int i = 0; i < 3; i++) begin
            flip_in = ~flip_in;
            step_count(3, pulses);
            total += pulses;
         end
         step_count(3, pulses);
         total += pulses;
         check("t4_pulses3", total, 3);
      end
      check("t4_count0", b_count, 0);
      enable = 1'b1;
      step_count(5, pulses);
      check("t4_reen_pulses", pulses, 0);
      check("t4_reen_count",  b_count, 0);

      // clear in the detect cycle drops the event
      flip_in = ~flip_in;
      step(2);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      check("t5_pulse", b_pulse, 1);
      check("t5_count", b_count, 0);
      step(3);
      check("t5_count_later", b_count, 0);

      // async reset mid-gap
      flip_in = ~flip_in; step(6);
      flip_in = ~flip_in; step(6);
      check("t6_pre_valid", b_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_count", b_count, 0);
      check("t6_rst_last",  b_last, 0);
      check("t6_rst_valid", b_valid, 0);
      check("t6_rst_s_max", s_max, 0);
      flip_in = 1'b1;
      step(2);
      rst = 1'b0;
      step_count(6, pulses);
      check("t6_release_pulses", pulses, 1);
      check("t6_release_count",  b_count, 1);
      check("t6_release_valid",  b_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flip_event_counter.md
FLIP_EVENT_COUNTER -- requirements
Module: flip_event_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on flip_in (legal 2..4).
REQ-002 Parameter CNT_WIDTH, default 32, width of event_count.
REQ-003 Parameter GAP_WIDTH, default 16, width of gap timer, last_gap and max_gap.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flip_in  input  1  toggle-encoded event line from the upstream edge-to-flip stage; each level change is one event; may be asynchronous to clk.
REQ-007 enable  input  1  1 = count events and run gap timer; 0 = freeze statistics.
REQ-008 clear  input  1  synchronous clear of statistics, one-cycle or held.
REQ-009 event_pulse  output  1  registered one-cycle pulse per detected flip_in change.
REQ-010 event_count  output  CNT_WIDTH  saturating count of counted events.
REQ-011 overflow  output  1  sticky; event arrived while event_count at all-ones.
REQ-012 last_gap  output  GAP_WIDTH  cycles between the two most recent counted events.
REQ-013 gap_valid  output  1  last_gap holds a real measurement (at least two counted events).
REQ-014 max_gap  output  GAP_WIDTH  largest last_gap since reset/clear.

Function
REQ-015 flip_in SHALL pass through a SYNC_STAGES-flop chain; its last stage is flip_sync.
REQ-016 Register flip_prev SHALL load flip_sync every cycle, regardless of enable or clear.
REQ-017 An event SHALL be detected when flip_sync differs from flip_prev.
REQ-018 event_pulse SHALL be registered: flip_in change ahead of edge N -> event_pulse high for exactly the cycle following edge N+SYNC_STAGES.
REQ-019 event_pulse SHALL be generated independent of enable and clear.
REQ-020 A counted event SHALL be a detected event with enable=1 and clear=0.
REQ-021 On a counted event event_count SHALL increment by 1, holding at all-ones; if already all-ones, overflow SHALL set and remain set until clear or reset.
REQ-022 Gap timer SHALL increment by 1 each cycle with enable=1, saturating at all-ones, and hold when enable=0.
REQ-023 On a counted event the gap timer SHALL reload to 1 (the event cycle counts as the first gap cycle).
REQ-024 On a counted event with first_seen=1, last_gap SHALL load the gap timer's pre-event value and gap_valid SHALL set.
REQ-025 On a counted event with first_seen=0, first_seen SHALL set; last_gap and gap_valid unchanged.
REQ-026 max_gap SHALL load the new last_gap value in the same cycle last_gap loads, if strictly greater than current max_gap.
REQ-027 Back-to-back events (flip_in toggling every cycle) SHALL each be counted, yielding last_gap=1.
REQ-028 clear=1 SHALL zero event_count, overflow, last_gap, gap_valid, max_gap, first_seen and gap timer on the next edge; clear wins over a simultaneous event, which is dropped from statistics.
REQ-029 Re-asserting enable SHALL NOT create an event; only flip_sync/flip_prev mismatch does.
REQ-030 All outputs SHALL be driven directly from flops.

Reset
REQ-031 rst=1 SHALL asynchronously zero synchronizer chain, flip_prev, first_seen, gap timer and all outputs.
REQ-032 After rst release with flip_in=1, the propagating 1 SHALL produce exactly one event (matching upstream reset level 0).
REQ-033 rst asserted mid-measurement SHALL discard all statistics; no partial gap retained.

Verification
REQ-034 SYNC_STAGES=2, enable=1, single flip_in 0->1 -> event_pulse high one cycle, 3rd edge after change; event_count=1, gap_valid=0.
REQ-035 Toggles 10 cycles apart then 25 cycles apart -> last_gap=10 then 25, max_gap=25, event_count=3, gap_valid=1.
REQ-036 CNT_WIDTH=4, 17 events -> event_count=15, overflow=1; clear -> all statistics 0, overflow=0.
REQ-037 enable=0 during 3 toggles -> 3 event_pulses, event_count unchanged; re-enable with flip_in stable -> no event.
REQ-038 clear asserted in the cycle an event is detected -> event_pulse=1, event_count=0 after edge.
REQ-039 GAP_WIDTH=4, 20-cycle gap -> last_gap=15 (saturated); rst mid-gap -> all outputs 0 immediately.
